seq_det_prog: RTL and testbench

Programmable serial bit-pattern detector, the parametrised successor to the fixed "101010" Mealy detector.
- Pattern (1..MAX_LEN bits) and overlap mode are loaded at runtime.
- Input is qualified by a valid strobe.
- Provides a saturating match counter and a configuration-error flag.
- Sits on serial framing/sync paths; match feeds downstream frame-alignment logic.

---
 rtl/seq_det_prog_if.sv | 29 ++
 rtl/seq_det_prog.sv | 109 ++++++++++
 tb/tb_seq_det_prog.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/seq_det_prog_if.sv
// Serial bit stream, runtime pattern configuration and match/status outputs of seq_det_prog.
// master = stimulus/configuration side, slave = the detector.
interface seq_det_prog_if #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic               in_valid;
   logic               in_bit;
   logic               pat_load;
   logic [MAX_LEN-1:0] pat_value;
   logic [LEN_W-1:0]   pat_len;
   logic               overlap_en;
   logic               cnt_clr;
   logic               match;
   logic [CNT_W-1:0]   match_cnt;
   logic               cfg_err;

   modport master (
      output in_valid, in_bit, pat_load, pat_value, pat_len, overlap_en, cnt_clr,
      input  match, match_cnt, cfg_err
   );

   modport slave (
      input  in_valid, in_bit, pat_load, pat_value, pat_len, overlap_en, cnt_clr,
      output match, match_cnt, cfg_err
   );
endinterface

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector; match is Mealy (same cycle as the final bit),
// counter/status are registered. No backpressure: every valid bit is consumed.
module seq_det_prog #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
) (
   input logic           clk,
   input logic           rst,
   seq_det_prog_if.slave bus
);
   localparam int                 LEN_W     = $clog2(MAX_LEN + 1);
   localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0]   DEF_LEN   = LEN_W'(6);
   localparam logic [MAX_LEN-1:0] DEF_PAT   = MAX_LEN'(6'b101010);
   localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic               ovl_q, ovl_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [MAX_LEN-1:0] len_mask;
   logic [MAX_LEN-1:0] load_mask;
   logic [MAX_LEN-1:0] cand;
   logic               len_legal;
   logic               take_bit;
   logic               match;

   // Masks select the low len bits; the stored pattern is kept pre-masked.
   always_comb begin
      len_mask  = '0;
      load_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i]  = (LEN_W'(i) < len_q);
         load_mask[i] = (LEN_W'(i) < bus.pat_len);
      end
   end

   assign len_legal = (bus.pat_len != '0) && (bus.pat_len <= MAX_LEN_L);
   assign take_bit  = bus.in_valid && !bus.pat_load && !rst;
   assign cand      = {hist_q[MAX_LEN-2:0], bus.in_bit};
   assign match     = take_bit
                      && (fill_q >= (len_q - LEN_W'(1)))
                      && ((cand & len_mask) == pat_q);

   always_comb begin
      pat_d  = pat_q;
      len_d  = len_q;
      ovl_d  = ovl_q;
      err_d  = err_q;
      hist_d = hist_q;
      fill_d = fill_q;
      cnt_d  = cnt_q;

      if (bus.pat_load) begin
         hist_d = '0;
         fill_d = '0;
         if (len_legal) begin
            pat_d = bus.pat_value & load_mask;
            len_d = bus.pat_len;
            ovl_d = bus.overlap_en;
            err_d = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end else if (bus.in_valid) begin
         hist_d = cand;
         // Non-overlapping mode restarts the fill so no matched bit is reused.
         if (match && !ovl_q) begin
            fill_d = '0;
         end else if (fill_q != MAX_LEN_L) begin
            fill_d = fill_q + LEN_W'(1);
         end
      end

      if (bus.cnt_clr) begin
         cnt_d = match ? CNT_W'(1) : '0;
      end else if (match && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q  <= DEF_PAT;
         len_q  <= DEF_LEN;
         ovl_q  <= 1'b1;
         err_q  <= 1'b0;
         hist_q <= '0;
         fill_q <= '0;
         cnt_q  <= '0;
      end else begin
         pat_q  <= pat_d;
         len_q  <= len_d;
         ovl_q  <= ovl_d;
         err_q  <= err_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.match     = match;
   assign bus.match_cnt = cnt_q;
   assign bus.cfg_err   = err_q;
endmodule

// File: tb/tb_seq_det_prog.sv
// Directed bench for seq_det_prog: vector table on an 8-bit-counter instance,
// plus hand-written sequences for full-length patterns and a 2-bit saturating counter.
module tb_seq_det_prog;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   seq_det_prog_if #(.MAX_LEN(8), .CNT_W(8)) b1 ();
   seq_det_prog_if #(.MAX_LEN(8), .CNT_W(2)) b2 ();

   seq_det_prog #(.MAX_LEN(8), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
   seq_det_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

   typedef struct {
      logic       rst;
      logic       v;
      logic       b;
      logic       ld;
      logic [7:0] pv;
      logic [3:0] pl;
      logic       ov;
      logic       clr;
      logic       em;
      logic [7:0] ec;
      logic       ee;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic v, logic b, logic ld, logic [7:0] pv,
                               logic [3:0] pl, logic ov, logic clr,
                               logic em, logic [7:0] ec, logic ee);
      vec_t x;
      x.rst = r;  x.v = v;   x.b = b;    x.ld = ld; x.pv = pv; x.pl = pl;
      x.ov = ov;  x.clr = clr; x.em = em; x.ec = ec; x.ee = ee;
      return x;
   endfunction

   function automatic vec_t bitv(logic b, logic em, logic [7:0] ec, logic ee);
      return mk(1'b0, 1'b1, b, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, em, ec, ee);
   endfunction

   function automatic vec_t idle(logic [7:0] ec, logic ee);
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, ec, ee);
   endfunction

   function automatic vec_t load(logic [7:0] pv, logic [3:0] pl, logic ov, logic clr,
                                 logic [7:0] ec, logic ee);
      return mk(1'b0, 1'b0, 1'b0, 1'b1, pv, pl, ov, clr, 1'b0, ec, ee);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drive one cycle on dut1, check at the falling edge, return just after the next rising edge.
   task automatic apply(input vec_t x, input string nm);
      rst           = x.rst;
      b1.in_valid   = x.v;
      b1.in_bit     = x.b;
      b1.pat_load   = x.ld;
      b1.pat_value  = x.pv;
      b1.pat_len    = x.pl;
      b1.overlap_en = x.ov;
      b1.cnt_clr    = x.clr;
      @(negedge clk);
      chk({nm, " match"}, 32'(b1.match), 32'(x.em));
      chk({nm, " cnt"}, 32'(b1.match_cnt), 32'(x.ec));
      chk({nm, " err"}, 32'(b1.cfg_err), 32'(x.ee));
      @(posedge clk);
      #1;
   endtask

   task automatic drive2(input logic v, input logic b, input logic clr);
      b2.in_valid = v;
      b2.in_bit   = b;
      b2.cnt_clr  = clr;
   endtask

   initial begin
      logic [7:0] p8;
      int         prev;

      b1.in_valid = 1'b0; b1.in_bit = 1'b0; b1.pat_load = 1'b0; b1.pat_value = '0;
      b1.pat_len = '0; b1.overlap_en = 1'b0; b1.cnt_clr = 1'b0;
      b2.in_valid = 1'b0; b2.in_bit = 1'b0; b2.pat_load = 1'b0; b2.pat_value = '0;
      b2.pat_len = '0; b2.overlap_en = 1'b0; b2.cnt_clr = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Reset cycle: a would-be completing bit must not match.
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0));
      // Default 101010 overlapping: 1010101010 matches on bits 6, 8, 10.
      for (int i = 1; i <= 10; i++)
         tbl.push_back(bitv(logic'(i % 2), (i == 6 || i == 8 || i == 10),
                            (i <= 6) ? 8'd0 : (i <= 8) ? 8'd1 : 8'd2, 1'b0));
      tbl.push_back(idle(8'd3, 1'b0));
      // 1101 non-overlapping, counter cleared on load: matches on bits 4 and 11 only.
      tbl.push_back(load(8'b0000_1101, 4'd4, 1'b0, 1'b1, 8'd3, 1'b0));
      p8 = 8'd0;
      begin
         logic [10:0] s;
         s = 11'b1101101_1101;
         for (int i = 1; i <= 11; i++)
            tbl.push_back(bitv(s[11 - i], (i == 4 || i == 11), (i <= 4) ? 8'd0 : 8'd1, 1'b0));
      end
      tbl.push_back(idle(8'd2, 1'b0));
      // Default pattern with a 5-cycle gap whose in_bit would have completed it.
      tbl.push_back(load(8'b0010_1010, 4'd6, 1'b1, 1'b1, 8'd2, 1'b0));
      for (int i = 1; i <= 5; i++) tbl.push_back(bitv(logic'(i % 2), 1'b0, 8'd0, 1'b0));
      for (int i = 0; i < 5; i++) tbl.push_back(idle(8'd0, 1'b0));
      tbl.push_back(bitv(1'b0, 1'b1, 8'd0, 1'b0));
      tbl.push_back(idle(8'd1, 1'b0));
      // Illegal len 0: config kept (overlap still on), history cleared, cfg_err set.
      tbl.push_back(load(8'h00, 4'd0, 1'b0, 1'b0, 8'd1, 1'b0));
      for (int i = 1; i <= 8; i++)
         tbl.push_back(bitv(logic'(i % 2), (i == 6 || i == 8), (i <= 6) ? 8'd1 : 8'd2, 1'b1));
      tbl.push_back(idle(8'd3, 1'b1));
      // Legal len 3 "111" (upper pattern bits ignored), overlapping.
      tbl.push_back(load(8'b1010_0111, 4'd3, 1'b1, 1'b0, 8'd3, 1'b1));
      for (int i = 1; i <= 4; i++)
         tbl.push_back(bitv(1'b1, (i >= 3), (i <= 3) ? 8'd3 : 8'd4, 1'b0));
      tbl.push_back(idle(8'd5, 1'b0));
      // Illegal len 9 (> MAX_LEN): 111 stays active.
      tbl.push_back(load(8'hFF, 4'd9, 1'b0, 1'b0, 8'd5, 1'b0));
      for (int i = 1; i <= 3; i++) tbl.push_back(bitv(1'b1, (i == 3), 8'd5, 1'b1));
      tbl.push_back(idle(8'd6, 1'b1));
      // Reset mid-stream discards history; load in a completing cycle drops the bit.
      tbl.push_back(load(8'b0010_1010, 4'd6, 1'b1, 1'b0, 8'd6, 1'b1));
      for (int i = 1; i <= 5; i++) tbl.push_back(bitv(logic'(i % 2), 1'b0, 8'd6, 1'b0));
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 8'd6, 1'b0));
      tbl.push_back(bitv(1'b0, 1'b0, 8'd0, 1'b0));
      for (int i = 1; i <= 5; i++) tbl.push_back(bitv(logic'(i % 2), 1'b0, 8'd0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'b0010_1010, 4'd6, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0));
      tbl.push_back(bitv(1'b0, 1'b0, 8'd0, 1'b0));
      tbl.push_back(idle(8'd0, 1'b0));
      // Length 1, non-overlapping: every matching bit fires.
      tbl.push_back(load(8'hFF, 4'd1, 1'b0, 1'b0, 8'd0, 1'b0));
      tbl.push_back(bitv(1'b1, 1'b1, 8'd0, 1'b0));
      tbl.push_back(bitv(1'b0, 1'b0, 8'd1, 1'b0));
      tbl.push_back(bitv(1'b1, 1'b1, 8'd1, 1'b0));
      tbl.push_back(idle(8'd2, 1'b0));

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

      // Full-length pattern sent twice back to back, non-overlapping.
      p8 = 8'b1100_1011;
      apply(load(p8, 4'd8, 1'b0, 1'b0, 8'd2, 1'b0), "len8 load");
      for (int k = 0; k < 16; k++)
         apply(bitv(p8[7 - (k % 8)], (k == 7 || k == 15), (k < 8) ? 8'd2 : 8'd3, 1'b0),
               $sformatf("len8 bit%0d", k));
      apply(idle(8'd4, 1'b0), "len8 idle");

      // 2-bit counter saturates at 3; clear coinciding with a match yields 1.
      for (int i = 1; i <= 16; i++) begin
         drive2(1'b1, logic'(i % 2), (i == 16));
         @(negedge clk);
         prev = (i <= 6) ? 0 : ((i - 7) / 2 + 1);
         chk($sformatf("sat match%0d", i), 32'(b2.match), 32'(i >= 6 && (i % 2) == 0));
         chk($sformatf("sat cnt%0d", i), 32'(b2.match_cnt), 32'((prev > 3) ? 3 : prev));
         @(posedge clk);
         #1;
      end
      drive2(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("sat clr+match", 32'(b2.match_cnt), 32'd1);
      @(posedge clk);
      #1;
      drive2(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("sat clr alone", 32'(b2.match_cnt), 32'd0);
      @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
